// File: rtl/pi_window_pkg.sv
// pi_window_pkg: shared types and constants for the PI window bridge.
//   - pi_state_t   : bridge FSM states (ST_PREFETCH exists only when
//                    PI_READ_PREFETCH_EN is defined)
//   - AD_W, PI_AW  : PI AD bus width and full PI address width
//   - LOG2_W       : width of one packed window-size field
//   - SI_*         : bit positions of the four PI strobes in the sync vector
//   - win_field()  : pulls field <idx> of <width> bits out of a packed
//                    per-window parameter vector
package pi_window_pkg;

    localparam int AD_W        = 16;
    localparam int PI_AW       = 32;
    localparam int LOG2_W      = 5;
    localparam int MAX_WIN     = 8;
    localparam int FIELD_VEC_W = MAX_WIN * PI_AW;
    localparam int CNT_W       = 4;
    localparam int INC_W       = 13;

    // Strobe vector layout; ALEs idle low, PI strobes idle high.
    localparam int NUM_STROBES = 4;
    localparam int SI_ALEH     = 0;
    localparam int SI_ALEL     = 1;
    localparam int SI_RD_N     = 2;
    localparam int SI_WR_N     = 3;
    localparam logic [NUM_STROBES-1:0] STROBE_IDLE = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ACCESS  = 3'd1,
        ST_RD_HOLD    = 3'd2,
        ST_WR_PULSE   = 3'd3,
`ifdef PI_READ_PREFETCH_EN
        ST_WR_RECOVER = 3'd4,
        ST_PREFETCH   = 3'd5
`else
        ST_WR_RECOVER = 3'd4
`endif
    } pi_state_t;

    // Field <idx> of a packed vector whose fields are <width> bits each,
    // field 0 in the least significant bits.
    function automatic logic [PI_AW-1:0] win_field(input logic [FIELD_VEC_W-1:0] vec,
                                                   input int idx, input int width);
        logic [FIELD_VEC_W-1:0] shifted;
        logic [PI_AW-1:0]       mask;
        shifted = vec >> (idx * width);
        mask    = (width >= PI_AW) ? '1 : ((PI_AW'(1) << width) - PI_AW'(1));
        return shifted[PI_AW-1:0] & mask;
    endfunction

endpackage

// File: rtl/pi_strobe_sync.sv
// pi_strobe_sync: SYNC_STAGES-deep synchroniser for the four PI strobes
// with edge detection on the last two stages.
//   clk, rst : clock, asynchronous active-high reset (stages load idle levels)
//   raw      : asynchronous strobes {write_n, read_n, alel, aleh}
//   level    : fully synchronised level (last stage)
//   rise     : one-clock pulse on a synchronised 0->1 transition
//   fall     : one-clock pulse on a synchronised 1->0 transition
module pi_strobe_sync
    import pi_window_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_STROBES-1:0] raw,
    output logic [NUM_STROBES-1:0] level,
    output logic [NUM_STROBES-1:0] rise,
    output logic [NUM_STROBES-1:0] fall
);

    logic [NUM_STROBES-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= STROBE_IDLE;
        end else begin
            stage[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    // stage[SYNC_STAGES-2] is the newer sample, stage[SYNC_STAGES-1] the older.
    assign level = stage[SYNC_STAGES-1];
    assign rise  = stage[SYNC_STAGES-2] & ~stage[SYNC_STAGES-1];
    assign fall  = ~stage[SYNC_STAGES-2] & stage[SYNC_STAGES-1];

endmodule

// File: rtl/pi_window_bridge.sv
// pi_window_bridge: N64 PI-bus slave front end. Latches the multiplexed PI
// address, decodes it against NUM_WIN windows and runs timed flash
// read/write cycles, returning read data on AD. A sticky boot_mode flag
// gates boot-only windows until the boot-exit write is seen.
// Optional feature: define PI_READ_PREFETCH_EN to prefetch the next
// halfword after each read into a tagged one-entry buffer.
//   clk, cold_reset          : clock, asynchronous active-high reset
//   ad_in / ad_out / ad_oe   : PI AD bus in, drive value, drive enable
//   aleh, alel               : PI address latch enables (high/low half)
//   read_n, write_n          : PI strobes, active-low
//   mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_wdata, mem_rdata, mem_dir
//                            : parallel flash interface (mem_dir=1: FPGA drives)
//   win_hit                  : registered one-hot decode of the latched address
//   boot_mode                : 1 from reset until the boot-exit write
// Read handshake: a synchronised read_n fall with a hit starts the flash
// access; ad_oe rises with valid ad_out and holds until read_n rises.
module pi_window_bridge
    import pi_window_pkg::*;
#(
    parameter int                      NUM_WIN        = 4,
    parameter logic [NUM_WIN*32-1:0]   WIN_BASE       = {32'h1EC00000, 32'h10C00000,
                                                         32'h10001000, 32'h10000000},
    parameter logic [NUM_WIN*5-1:0]    WIN_LOG2       = {5'd20, 5'd20, 5'd17, 5'd6},
    parameter int                      MEM_AW         = 19,
    parameter logic [NUM_WIN*MEM_AW-1:0] WIN_OFFSET   = '0,
    parameter logic [NUM_WIN-1:0]      BOOT_ONLY      = 4'b1110,
    parameter int                      SYNC_STAGES    = 2,
    parameter int                      RD_CYCLES      = 4,
    parameter int                      WE_CYCLES      = 3,
    parameter logic [31:0]             BOOT_EXIT_ADDR = 32'h1E400600,
    parameter logic [15:0]             BOOT_EXIT_DATA = 16'h0012
) (
    input  logic              clk,
    input  logic              cold_reset,
    input  logic [15:0]       ad_in,
    output logic [15:0]       ad_out,
    output logic              ad_oe,
    input  logic              aleh,
    input  logic              alel,
    input  logic              read_n,
    input  logic              write_n,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              mem_dir,
    output logic [NUM_WIN-1:0] win_hit,
    output logic              boot_mode
);

    localparam logic [FIELD_VEC_W-1:0] BASE_V = FIELD_VEC_W'(WIN_BASE);
    localparam logic [FIELD_VEC_W-1:0] LOG2_V = FIELD_VEC_W'(WIN_LOG2);
    localparam logic [FIELD_VEC_W-1:0] OFF_V  = FIELD_VEC_W'(WIN_OFFSET);

    logic [PI_AW-1:0]       addr;
    logic [INC_W-1:0]       inc;
    pi_state_t              state;
    logic [CNT_W-1:0]       cnt;
    logic                   pending;
    logic [NUM_STROBES-1:0] lvl, rise, fall;
    logic                   ale_act, rd_fall, rd_rise, wr_fall, wr_rise;
    logic [NUM_WIN-1:0]     hit_vec;
    logic                   hit_any;
    logic [MEM_AW-1:0]      hit_addr, off_i;
    logic [PI_AW-1:0]       base_i;
    logic [LOG2_W-1:0]      log2_i;
`ifdef PI_READ_PREFETCH_EN
    logic                   pf_valid;
    logic [MEM_AW-1:0]      pf_tag;
    logic [15:0]            pf_buf;
`endif

    pi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (cold_reset),
        .raw   ({write_n, read_n, alel, aleh}),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    // Any synchronised ALE level or edge counts as address-phase activity.
    assign ale_act = lvl[SI_ALEH] | lvl[SI_ALEL] | rise[SI_ALEH] | rise[SI_ALEL]
                   | fall[SI_ALEH] | fall[SI_ALEL];
    assign rd_fall = fall[SI_RD_N];
    assign rd_rise = rise[SI_RD_N];
    assign wr_fall = fall[SI_WR_N];
    assign wr_rise = rise[SI_WR_N];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_vec  = '0;
        hit_any  = 1'b0;
        hit_addr = '0;
        base_i   = '0;
        log2_i   = '0;
        off_i    = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            base_i = win_field(BASE_V, i, PI_AW);
            log2_i = LOG2_W'(win_field(LOG2_V, i, LOG2_W));
            off_i  = MEM_AW'(win_field(OFF_V, i, MEM_AW));
            if (((addr >> log2_i) == (base_i >> log2_i)) && (!BOOT_ONLY[i] || boot_mode)) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
                hit_any    = 1'b1;
                hit_addr   = off_i + MEM_AW'((addr - base_i) >> 1) + MEM_AW'(inc);
            end
        end
    end

    // Address latch, burst increment, decode register and boot flag.
    always_ff @(posedge clk or posedge cold_reset) begin
        if (cold_reset) begin
            addr      <= '0;
            inc       <= '0;
            win_hit   <= '0;
            boot_mode <= 1'b1;
        end else begin
            if (lvl[SI_ALEL] && !lvl[SI_ALEH]) begin
                addr[15:0] <= ad_in;
                inc        <= '0;
            end else begin
                if (lvl[SI_ALEL] && lvl[SI_ALEH]) addr[31:16] <= ad_in;
                if (rd_rise || wr_rise) inc <= inc + INC_W'(1);
            end
            win_hit <= hit_vec;
            if (wr_fall && addr == BOOT_EXIT_ADDR && ad_in == BOOT_EXIT_DATA) boot_mode <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge cold_reset) begin
        if (cold_reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            ad_out    <= '0;
            ad_oe     <= 1'b0;
            mem_addr  <= '0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_wdata <= '0;
            mem_dir   <= 1'b0;
`ifdef PI_READ_PREFETCH_EN
            pf_valid  <= 1'b0;
            pf_tag    <= '0;
            pf_buf    <= '0;
`endif
        end else begin
            // One-deep: a second fall while the flag is set changes nothing.
            if (rd_fall && state != ST_IDLE) pending <= 1'b1;
            if (ale_act && state != ST_IDLE) begin
                state    <= ST_IDLE;
                mem_ce_n <= 1'b1;
                mem_oe_n <= 1'b1;
                mem_we_n <= 1'b1;
                mem_dir  <= 1'b0;
                ad_oe    <= 1'b0;
                pending  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A deferred read is only worth starting while the
                        // host still holds read_n low and no write is active.
                        if (rd_fall || (pending && !lvl[SI_RD_N] && lvl[SI_WR_N])) begin
                            pending <= 1'b0;
                            if (hit_any) begin
                                mem_addr <= hit_addr;
                                mem_ce_n <= 1'b0;
                                mem_oe_n <= 1'b0;
                                cnt      <= '0;
                                state    <= ST_RD_ACCESS;
`ifdef PI_READ_PREFETCH_EN
                                if (pf_valid && pf_tag == hit_addr) begin
                                    ad_out <= pf_buf;
                                    ad_oe  <= 1'b1;
                                    state  <= ST_RD_HOLD;
                                end
`endif
                            end
                        end else if (wr_fall && hit_any) begin
                            mem_addr  <= hit_addr;
                            mem_wdata <= ad_in;
                            mem_dir   <= 1'b1;
                            mem_ce_n  <= 1'b0;
                            mem_we_n  <= 1'b0;
                            cnt       <= '0;
                            state     <= ST_WR_PULSE;
                        end else if (pending && lvl[SI_RD_N]) begin
                            pending <= 1'b0;
                        end
                    end
                    ST_RD_ACCESS: begin
                        if (rd_rise) begin
                            mem_ce_n <= 1'b1;
                            mem_oe_n <= 1'b1;
                            state    <= ST_IDLE;
                        end else if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                            ad_out <= mem_rdata;
                            ad_oe  <= 1'b1;
                            state  <= ST_RD_HOLD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RD_HOLD: begin
                        if (rd_rise) begin
                            ad_oe <= 1'b0;
`ifdef PI_READ_PREFETCH_EN
                            // Flash stays selected and walks on to the next halfword.
                            mem_addr <= mem_addr + MEM_AW'(1);
                            cnt      <= '0;
                            state    <= ST_PREFETCH;
`else
                            mem_ce_n <= 1'b1;
                            mem_oe_n <= 1'b1;
                            state    <= ST_IDLE;
`endif
                        end
                    end
`ifdef PI_READ_PREFETCH_EN
                    ST_PREFETCH: begin
                        if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                            pf_buf   <= mem_rdata;
                            pf_tag   <= mem_addr;
                            pf_valid <= 1'b1;
                            mem_ce_n <= 1'b1;
                            mem_oe_n <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
`endif
                    ST_WR_PULSE: begin
                        if (cnt == CNT_W'(WE_CYCLES - 1)) begin
                            mem_ce_n <= 1'b1;
                            mem_we_n <= 1'b1;
                            state    <= ST_WR_RECOVER;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_WR_RECOVER: begin
                        mem_dir <= 1'b0;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
`ifdef PI_READ_PREFETCH_EN
            if (ale_act || wr_fall) pf_valid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pi_window_bridge.sv
// tb_pi_window_bridge: directed bench for pi_window_bridge with the default
// window map (window 0 = 0x10000000/64B, 1 = 0x10001000/128KB boot-only,
// 2 = 0x10C00000/1MB boot-only, 3 = 0x1EC00000/1MB boot-only).
module tb_pi_window_bridge;
    import pi_window_pkg::*;

    localparam int MEM_AW = 19;

    logic              clk = 1'b0;
    logic              cold_reset;
    logic [15:0]       ad_in;
    logic [15:0]       ad_out;
    logic              ad_oe;
    logic              aleh, alel, read_n, write_n;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_ce_n, mem_oe_n, mem_we_n;
    logic [15:0]       mem_wdata, mem_rdata;
    logic              mem_dir;
    logic [3:0]        win_hit;
    logic              boot_mode;

    int n_checks = 0;
    int n_fail   = 0;

    pi_window_bridge dut (
        .clk       (clk),
        .cold_reset(cold_reset),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .aleh      (aleh),
        .alel      (alel),
        .read_n    (read_n),
        .write_n   (write_n),
        .mem_addr  (mem_addr),
        .mem_ce_n  (mem_ce_n),
        .mem_oe_n  (mem_oe_n),
        .mem_we_n  (mem_we_n),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_dir   (mem_dir),
        .win_hit   (win_hit),
        .boot_mode (boot_mode)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pi_latch(input logic [31:0] a);
        aleh = 1'b1; alel = 1'b1; ad_in = a[31:16]; tick(4);
        aleh = 1'b0; tick(4);
        ad_in = a[15:0]; tick(4);
        alel = 1'b0; tick(4);
    endtask

    // Full read: returns clocks from read_n low to ad_oe, plus address/data seen.
    task automatic pi_read(input logic [15:0] rdata, output int cyc,
                           output logic [MEM_AW-1:0] ma, output logic [15:0] d);
        mem_rdata = rdata;
        read_n    = 1'b0;
        cyc       = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ad_oe === 1'b1) break;
        end
        ma = mem_addr;
        d  = ad_out;
        read_n = 1'b1;
        tick(4);
    endtask

    task automatic read_pulse();
        read_n = 1'b0; @(negedge clk);
        read_n = 1'b1; @(negedge clk);
    endtask

    // Scenarios
    task automatic test_reset();
        cold_reset = 1'b1;
        ad_in = '0; aleh = 1'b0; alel = 1'b0; read_n = 1'b1; write_n = 1'b1; mem_rdata = '0;
        tick(3);
        cold_reset = 1'b0;
        tick(2);
        n_checks++;
        if ({ad_out, ad_oe, mem_dir} !== 18'h0) begin
            n_fail++; $display("FAIL reset_ad: got ad_out=%h ad_oe=%b dir=%b expected 0/0/0", ad_out, ad_oe, mem_dir);
        end
        n_checks++;
        if ({mem_ce_n, mem_oe_n, mem_we_n} !== 3'b111) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 111", {mem_ce_n, mem_oe_n, mem_we_n});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || win_hit !== 4'b0) begin
            n_fail++; $display("FAIL reset_regs: got addr=%h wdata=%h hit=%b expected 0", mem_addr, mem_wdata, win_hit);
        end
        n_checks++;
        if (boot_mode !== 1'b1 || dut.state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_boot: got boot=%b state=%0d expected 1/IDLE", boot_mode, dut.state);
        end
    endtask

    task automatic test_boot_read();
        int cyc; logic [MEM_AW-1:0] ma; logic [15:0] d;
        pi_latch(32'h10001000);
        n_checks++;
        if (win_hit !== 4'b0010) begin
            n_fail++; $display("FAIL boot_read_hit: got %b expected 0010", win_hit);
        end
        pi_read(16'hA5A5, cyc, ma, d);
        n_checks++;
        if (cyc !== 6) begin
            n_fail++; $display("FAIL boot_read_latency: got %0d expected 6", cyc);
        end
        n_checks++;
        if (ma !== 19'd0 || d !== 16'hA5A5) begin
            n_fail++; $display("FAIL boot_read_data: got addr=%h data=%h expected 0/a5a5", ma, d);
        end
        n_checks++;
        if (ad_oe !== 1'b0 || mem_ce_n !== 1'b1 || mem_oe_n !== 1'b1 || dut.state !== ST_IDLE) begin
            n_fail++; $display("FAIL boot_read_release: got oe=%b ce_n=%b oe_n=%b expected 0/1/1", ad_oe, mem_ce_n, mem_oe_n);
        end
    endtask

    task automatic test_burst();
        int cyc; logic [MEM_AW-1:0] ma; logic [15:0] d;
        pi_latch(32'h1EC00010);
        n_checks++;
        if (win_hit !== 4'b1000) begin
            n_fail++; $display("FAIL burst_hit: got %b expected 1000", win_hit);
        end
        for (int k = 0; k < 4; k++) begin
            pi_read(16'h0C00 + 16'(k), cyc, ma, d);
            n_checks++;
            if (ma !== 19'(8 + k) || d !== 16'h0C00 + 16'(k)) begin
                n_fail++; $display("FAIL burst_read%0d: got addr=%0d data=%h expected %0d/%h", k, ma, d, 8 + k, 16'h0C00 + 16'(k));
            end
        end
        // inc is now 4; 8187 more strobes bring it to 8191.
        for (int k = 0; k < 8187; k++) read_pulse();
        tick(4);
        pi_read(16'h7777, cyc, ma, d);
        n_checks++;
        if (ma !== 19'd8199) begin
            n_fail++; $display("FAIL burst_inc_max: got %0d expected 8199", ma);
        end
        pi_read(16'h8888, cyc, ma, d);
        n_checks++;
        if (ma !== 19'd8 || d !== 16'h8888) begin
            n_fail++; $display("FAIL burst_inc_wrap: got addr=%0d data=%h expected 8/8888", ma, d);
        end
    endtask

    task automatic test_write();
        int we_cnt, rec_cnt, cyc, ce_bad; logic seen_we; logic [MEM_AW-1:0] ma; logic [15:0] wd;
        pi_latch(32'h1EC00002);
        ad_in = 16'h1234; write_n = 1'b0;
        we_cnt = 0; rec_cnt = 0; cyc = 0; ce_bad = 0; seen_we = 1'b0; ma = '0; wd = '0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_we_n === 1'b0) begin
                we_cnt++; seen_we = 1'b1; ma = mem_addr; wd = mem_wdata;
                if (mem_ce_n !== 1'b0 || mem_dir !== 1'b1) ce_bad++;
            end else if (seen_we && mem_dir === 1'b1) begin
                rec_cnt++;
            end else if (seen_we) begin
                break;
            end
        end
        n_checks++;
        if (ma !== 19'd1 || wd !== 16'h1234) begin
            n_fail++; $display("FAIL write_data: got addr=%0d wdata=%h expected 1/1234", ma, wd);
        end
        n_checks++;
        if (we_cnt !== 3 || ce_bad !== 0) begin
            n_fail++; $display("FAIL write_pulse: got we_low=%0d ce_dir_bad=%0d expected 3/0", we_cnt, ce_bad);
        end
        n_checks++;
        if (rec_cnt !== 1 || mem_dir !== 1'b0 || mem_ce_n !== 1'b1) begin
            n_fail++; $display("FAIL write_recover: got rec=%0d dir=%b ce_n=%b expected 1/0/1", rec_cnt, mem_dir, mem_ce_n);
        end
        write_n = 1'b1; tick(4);
    endtask

    task automatic test_abort();
        int cyc; int oe_seen;
        pi_latch(32'h10C00000);
        ad_in = 16'h0000;
        read_n = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk); cyc++;
            if (mem_ce_n === 1'b0) break;
        end
        alel = 1'b1;
        cyc = 0; oe_seen = 0;
        while (cyc < 10) begin
            @(negedge clk); cyc++;
            if (ad_oe === 1'b1) oe_seen++;
            if (mem_ce_n === 1'b1) break;
        end
        n_checks++;
        if (cyc !== 2 || oe_seen !== 0) begin
            n_fail++; $display("FAIL abort_timing: got clocks=%0d oe_seen=%0d expected 2/0", cyc, oe_seen);
        end
        n_checks++;
        if (mem_oe_n !== 1'b1 || mem_we_n !== 1'b1 || ad_oe !== 1'b0 || dut.state !== ST_IDLE) begin
            n_fail++; $display("FAIL abort_state: got oe_n=%b ad_oe=%b state=%0d expected 1/0/IDLE", mem_oe_n, ad_oe, dut.state);
        end
        tick(2); alel = 1'b0; tick(6);
        n_checks++;
        if (ad_oe !== 1'b0 || mem_ce_n !== 1'b1) begin
            n_fail++; $display("FAIL abort_no_restart: got ad_oe=%b ce_n=%b expected 0/1", ad_oe, mem_ce_n);
        end
        read_n = 1'b1; tick(4);
    endtask

    task automatic test_boot_exit();
        int bad;
        pi_latch(32'h1E400600);
        n_checks++;
        if (win_hit !== 4'b0000) begin
            n_fail++; $display("FAIL exit_addr_hit: got %b expected 0000", win_hit);
        end
        ad_in = 16'h0013; write_n = 1'b0; tick(4); write_n = 1'b1; tick(4);
        n_checks++;
        if (boot_mode !== 1'b1) begin
            n_fail++; $display("FAIL exit_wrong_data: got boot=%b expected 1", boot_mode);
        end
        ad_in = 16'h0012; write_n = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_we_n !== 1'b1 || mem_ce_n !== 1'b1) bad++;
        end
        write_n = 1'b1; tick(4);
        n_checks++;
        if (boot_mode !== 1'b0 || bad !== 0) begin
            n_fail++; $display("FAIL exit_write: got boot=%b strobe_clocks=%0d expected 0/0", boot_mode, bad);
        end
        pi_latch(32'h10001000);
        n_checks++;
        if (win_hit !== 4'b0000) begin
            n_fail++; $display("FAIL exit_boot_win_hit: got %b expected 0000", win_hit);
        end
        mem_rdata = 16'h5A5A; read_n = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ad_oe !== 1'b0 || mem_ce_n !== 1'b1) bad++;
        end
        read_n = 1'b1; tick(4);
        n_checks++;
        if (bad !== 0 || boot_mode !== 1'b0) begin
            n_fail++; $display("FAIL exit_read_ignored: got active_clocks=%0d boot=%b expected 0/0", bad, boot_mode);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        pi_latch(32'h10000004);
        n_checks++;
        if (win_hit !== 4'b0001) begin
            n_fail++; $display("FAIL rst_write_hit: got %b expected 0001", win_hit);
        end
        ad_in = 16'hBEEF; write_n = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk); cyc++;
            if (mem_we_n === 1'b0) break;
        end
        n_checks++;
        if (mem_we_n !== 1'b0 || mem_dir !== 1'b1 || mem_addr !== 19'd2 || mem_wdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL rst_write_pulse: got we_n=%b dir=%b addr=%0d wdata=%h expected 0/1/2/beef", mem_we_n, mem_dir, mem_addr, mem_wdata);
        end
        cold_reset = 1'b1;
        #1;
        n_checks++;
        if (mem_we_n !== 1'b1 || mem_ce_n !== 1'b1 || mem_dir !== 1'b0 || boot_mode !== 1'b1) begin
            n_fail++; $display("FAIL rst_async: got we_n=%b ce_n=%b dir=%b boot=%b expected 1/1/0/1", mem_we_n, mem_ce_n, mem_dir, boot_mode);
        end
        write_n = 1'b1;
        tick(3);
        cold_reset = 1'b0;
        tick(4);
        n_checks++;
        if (dut.state !== ST_IDLE || win_hit !== 4'b0000 || mem_addr !== '0) begin
            n_fail++; $display("FAIL rst_after: got state=%0d hit=%b addr=%h expected IDLE/0000/0", dut.state, win_hit, mem_addr);
        end
    endtask

    // Sequence and report
    initial begin
        test_reset();
        test_boot_read();
        test_burst();
        test_write();
        test_abort();
        test_boot_exit();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
